// File: rtl/cl_pkg.sv
// -----------------------------------------------------------------------------
// cl_pkg
//
// Shared definitions for the Camera Link capture sequencer:
//   - frame-count field width and the derived opcode width of a PC command
//   - PC command opcodes and status-word result codes
//   - the sequencer state encoding
//   - a packed view of a PC command word and the status-word pack helper
// -----------------------------------------------------------------------------
package cl_pkg;

    // Width of the frame-count field carried in commands and status words.
    localparam int N_FRAME_SIZE = 20;

    // Everything above the frame-count field is the opcode.
    localparam int OPC_W = 32 - N_FRAME_SIZE;

    // PC command opcodes.
    localparam logic [OPC_W-1:0] OPC_CAPTURE     = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_ABORT       = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_STATUS      = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_SET_TIMEOUT = OPC_W'(4);

    // Result codes carried in the status word.
    localparam logic [3:0] CODE_DONE         = 4'd1;
    localparam logic [3:0] CODE_TIMEOUT      = 4'd2;
    localparam logic [3:0] CODE_ABORTED      = 4'd3;
    localparam logic [3:0] CODE_STATUS_REPLY = 4'd4;
    localparam logic [3:0] CODE_BAD_CMD      = 4'd5;

    // Marker nibble in the top of every status word, so the PC can tell
    // status words apart from captured data on the shared channel.
    localparam logic [3:0] STATUS_TAG = 4'hF;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } cl_state_e;

    // Field view of a PC command word.
    typedef struct packed {
        logic [OPC_W-1:0]        opcode;
        logic [N_FRAME_SIZE-1:0] arg;
    } cl_cmd_t;

    // Status word layout: {tag, code, seq, n_frame}.
    function automatic logic [31:0] cl_pack_status(
        input logic [3:0]              code,
        input logic [3:0]              seq,
        input logic [N_FRAME_SIZE-1:0] n_frame
    );
        return {STATUS_TAG, code, seq, n_frame};
    endfunction

endpackage

// File: rtl/cl_msg_arb.sv
// -----------------------------------------------------------------------------
// cl_msg_arb
//
// 2:1 arbiter for the single outbound FPGA message channel. While a status
// word is pending it owns the channel and the captured-data stream is held
// off; otherwise captured data flows straight through whenever the outbound
// FIFO has room.
//
// Handshake: a data word transfers on a clock edge where data_valid and
// data_ready are both high; data_ready never depends on data_valid. The
// outbound FIFO is written on every edge where fpga_msg_valid is high.
//
// Ports:
//   status_sel     in  1  status word pending (owns the channel)
//   status_word    in  32 status word to emit
//   data_msg       in  32 captured data word
//   data_valid     in  1  captured data word available
//   data_ready     out 1  captured data word accepted this cycle
//   fpga_msg_full  in  1  outbound FIFO full
//   fpga_msg       out 32 outbound word (zero when nothing is written)
//   fpga_msg_valid out 1  outbound write strobe
// -----------------------------------------------------------------------------
module cl_msg_arb (
    input  logic        status_sel,
    input  logic [31:0] status_word,
    input  logic [31:0] data_msg,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        fpga_msg_full,
    output logic [31:0] fpga_msg,
    output logic        fpga_msg_valid
);

    always_comb begin
        data_ready     = 1'b0;
        fpga_msg_valid = 1'b0;
        fpga_msg       = '0;
        if (status_sel) begin
            fpga_msg_valid = !fpga_msg_full;
            if (!fpga_msg_full) begin
                fpga_msg = status_word;
            end
        end else begin
            data_ready     = !fpga_msg_full;
            fpga_msg_valid = data_valid && !fpga_msg_full;
            // The bus shows zero whenever nothing is being written, which
            // keeps the outbound word quiet during reset and stalls.
            if (data_valid && !fpga_msg_full) begin
                fpga_msg = data_msg;
            end
        end
    end

endmodule

// File: rtl/cl_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cl_capture_ctrl
//
// Bus-side sequencer for the Camera Link capture path. Decodes PC command
// words, hands arm commands to the capture block, supervises each capture
// with a timeout and an abort, and reports the outcome as a status word on
// the outbound FPGA message channel, which it shares with captured data.
//
// Handshakes:
//   - PC command: pc_msg is consumed on the edge where pc_msg_ack is high.
//     The ack is registered, so it rises the cycle after pc_msg_pending is
//     sampled, and pending is only sampled while the ack is low, so one word
//     is never decoded twice.
//   - Capture arm: cap_cmd transfers on an edge where cap_cmd_valid and
//     cap_cmd_ack are both high; cap_cmd_valid drops the following cycle.
//   - Data stream: data_msg transfers on an edge with data_valid and
//     data_ready high (see cl_msg_arb).
//
// Ports:
//   bus_clk        in  1  sole clock
//   reset          in  1  synchronous, active-high
//   pc_msg_pending in  1  PC command word available
//   pc_msg         in  32 PC command word {opcode, argument}
//   pc_msg_ack     out 1  one-cycle pulse consuming pc_msg
//   cap_cmd_valid  out 1  arm request to the capture block
//   cap_cmd        out 32 arm word {12'h001, n_frame}, zero when idle
//   cap_cmd_ack    in  1  capture block accepted cap_cmd
//   cap_done       in  1  one-cycle pulse, capture finished
//   cap_abort      out 1  one-cycle pulse, capture block returns to standby
//   data_msg       in  32 captured data word
//   data_valid     in  1  captured data word available
//   data_ready     out 1  captured data word accepted
//   fpga_msg_full  in  1  outbound FIFO full
//   fpga_msg       out 32 outbound word
//   fpga_msg_valid out 1  outbound write strobe
//   busy           out 1  high in every state except IDLE
//   dbg_state      out 2  current sequencer state
// -----------------------------------------------------------------------------
module cl_capture_ctrl
    import cl_pkg::*;
#(
    parameter int                   TIMEOUT_W       = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_DEFAULT = 24'hFF_FFFF
) (
    input  logic        bus_clk,
    input  logic        reset,
    input  logic        pc_msg_pending,
    input  logic [31:0] pc_msg,
    output logic        pc_msg_ack,
    output logic        cap_cmd_valid,
    output logic [31:0] cap_cmd,
    input  logic        cap_cmd_ack,
    input  logic        cap_done,
    output logic        cap_abort,
    input  logic [31:0] data_msg,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        fpga_msg_full,
    output logic [31:0] fpga_msg,
    output logic        fpga_msg_valid,
    output logic        busy,
    output cl_state_e   dbg_state
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    cl_state_e               state_q,   state_d;
    logic                    ack_q,     ack_d;
    logic                    abort_q,   abort_d;
    logic [3:0]              seq_q,     seq_d;
    logic [N_FRAME_SIZE-1:0] n_frame_q, n_frame_d;
    logic [3:0]              code_q,    code_d;
    logic [TIMEOUT_W-1:0]    limit_q,   limit_d;
    logic [TIMEOUT_W-1:0]    cnt_q,     cnt_d;

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    cl_cmd_t cmd;
    logic    msg_take;
    logic    abort_req;
    logic    timed_out;

    assign cmd       = cl_cmd_t'(pc_msg);
    // A word still showing while its ack is high is the one being consumed.
    assign msg_take  = pc_msg_pending && !ack_q;
    assign abort_req = msg_take && (cmd.opcode == OPC_ABORT);
    // Compare before the increment so a limit of 0 fires on the first RUN
    // cycle.
    assign timed_out = (cnt_q >= limit_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        abort_d   = 1'b0;
        seq_d     = seq_q;
        n_frame_d = n_frame_q;
        code_d    = code_q;
        limit_d   = limit_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (msg_take) begin
                    ack_d = 1'b1;
                    case (cmd.opcode)
                        OPC_CAPTURE: begin
                            if (cmd.arg != '0) begin
                                n_frame_d = cmd.arg;
                                seq_d     = seq_q + 4'd1;
                                state_d   = ST_ISSUE;
                            end else begin
                                // A zero-frame capture is refused; the
                                // previous frame count stays reported.
                                code_d  = CODE_BAD_CMD;
                                state_d = ST_REPORT;
                            end
                        end
                        OPC_ABORT: begin
                            // Nothing running: consumed with no effect.
                        end
                        OPC_STATUS: begin
                            code_d  = CODE_STATUS_REPLY;
                            state_d = ST_REPORT;
                        end
                        OPC_SET_TIMEOUT: begin
                            limit_d = TIMEOUT_W'(cmd.arg);
                        end
                        default: begin
                            code_d  = CODE_BAD_CMD;
                            state_d = ST_REPORT;
                        end
                    endcase
                end
            end

            ST_ISSUE: begin
                if (cap_cmd_ack) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Saturating count: a capture that outlives a wrap could
                // otherwise slip past the limit compare.
                if (cnt_q != {TIMEOUT_W{1'b1}}) begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
                if (cap_done) begin
                    // Completion wins over a coincident timeout or abort:
                    // the capture really finished, and a pending ABORT is
                    // left for IDLE to consume harmlessly.
                    code_d  = CODE_DONE;
                    state_d = ST_REPORT;
                end else if (abort_req) begin
                    // Covers the abort-and-timeout case too: one ack, one
                    // cap_abort pulse, reported as ABORTED.
                    ack_d   = 1'b1;
                    abort_d = 1'b1;
                    code_d  = CODE_ABORTED;
                    state_d = ST_REPORT;
                end else if (timed_out) begin
                    abort_d = 1'b1;
                    code_d  = CODE_TIMEOUT;
                    state_d = ST_REPORT;
                end
            end

            ST_REPORT: begin
                // The arbiter writes the status word on this same cycle
                // whenever the outbound FIFO has room.
                if (!fpga_msg_full) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge bus_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            abort_q   <= 1'b0;
            seq_q     <= 4'd0;
            n_frame_q <= '0;
            code_q    <= 4'd0;
            limit_q   <= TIMEOUT_DEFAULT;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            abort_q   <= abort_d;
            seq_q     <= seq_d;
            n_frame_q <= n_frame_d;
            code_q    <= code_d;
            limit_q   <= limit_d;
            cnt_q     <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic        status_sel;
    logic [31:0] status_word;

    assign pc_msg_ack    = ack_q;
    assign cap_abort     = abort_q;
    assign cap_cmd_valid = (state_q == ST_ISSUE);
    assign cap_cmd       = cap_cmd_valid ? {OPC_CAPTURE, n_frame_q} : '0;
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

    assign status_sel    = (state_q == ST_REPORT);
    assign status_word   = cl_pack_status(code_q, seq_q, n_frame_q);

    cl_msg_arb u_arb (
        .status_sel     (status_sel),
        .status_word    (status_word),
        .data_msg       (data_msg),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .fpga_msg_full  (fpga_msg_full),
        .fpga_msg       (fpga_msg),
        .fpga_msg_valid (fpga_msg_valid)
    );

endmodule
